// File: rtl/event_capture.sv
// Input-capture unit: synchronises an external event line, timestamps selected edges with count_in
// and queues {ovf, stamp} entries for a valid/ready reader. Optional macro CAP_OVERWRITE_EN: full FIFO drops oldest.
module event_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    nrst_in,
    input  logic                    en_ctl_in,
    input  logic [1:0]              edge_sel_in,
    input  logic                    evt_in,
    input  logic [WIDTH-1:0]        count_in,
    input  logic                    ovf_in,
    output logic [WIDTH-1:0]        cap_data_out,
    output logic                    cap_ovf_out,
    output logic                    cap_valid_out,
    input  logic                    cap_ready_in,
    output logic                    cap_lost_out,
    input  logic                    lost_clr_in,
    output logic [$clog2(DEPTH):0]  level_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_INC = AW'(1'b1);
    localparam logic [LW-1:0] LVL_INC = LW'(1'b1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic             s1_q, s2_q, s3_q;
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             lost_q, lost_d;
    logic             rise_s, fall_s, edge_s, push_req_s, full_s, valid_s, pop_s;
    logic             wr_en_s, adv_rd_s, drop_s;
    logic [WIDTH:0]   entry_s, head_s;

    assign rise_s     = s2_q & ~s3_q;
    assign fall_s     = ~s2_q & s3_q;
    assign push_req_s = en_ctl_in & edge_s;
    assign full_s     = (level_q == LVL_FULL);
    assign valid_s    = (level_q != {LW{1'b0}});
    assign pop_s      = valid_s & cap_ready_in;
    assign entry_s    = {ovf_pend_q | ovf_in, count_in};
    assign head_s     = mem_q[rd_ptr_q];

    // Edge selection from the synchronised event history.
    always_comb begin
        case (edge_sel_in)
            2'b00:   edge_s = rise_s;
            2'b01:   edge_s = fall_s;
            2'b10:   edge_s = rise_s | fall_s;
            default: edge_s = 1'b0;
        endcase
    end

    // Push/pop arbitration; a pop in the same cycle always frees room for the new entry.
    always_comb begin
        wr_en_s  = 1'b0;
        adv_rd_s = pop_s;
        drop_s   = 1'b0;
        if (push_req_s) begin
            if (!full_s || pop_s) begin
                wr_en_s = 1'b1;
            end else begin
                drop_s = 1'b1;
`ifdef CAP_OVERWRITE_EN
                wr_en_s  = 1'b1;
                adv_rd_s = 1'b1;
`endif
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state for pointers, level, pending overflow and sticky loss flag.
    always_comb begin
        wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_INC) : wr_ptr_q;
        rd_ptr_d = adv_rd_s ? (rd_ptr_q + PTR_INC) : rd_ptr_q;
        case ({wr_en_s, adv_rd_s})
            2'b10:   level_d = level_q + LVL_INC;
            2'b01:   level_d = level_q - LVL_INC;
            default: level_d = level_q;
        endcase
        // An overflow coinciding with a push is folded into that entry, not carried forward.
        if (!en_ctl_in) begin
            ovf_pend_d = 1'b0;
        end else if (wr_en_s) begin
            ovf_pend_d = 1'b0;
        end else if (ovf_in) begin
            ovf_pend_d = 1'b1;
        end else begin
            ovf_pend_d = ovf_pend_q;
        end
        if (drop_s) begin
            lost_d = 1'b1;
        end else if (lost_clr_in) begin
            lost_d = 1'b0;
        end else begin
            lost_d = lost_q;
        end
    end

    // Event synchroniser and edge history; runs regardless of enable so enabling is glitch-free.
    always_ff @(posedge clk_in or posedge nrst_in) begin
        if (nrst_in) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= evt_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // FIFO storage and control state.
    always_ff @(posedge clk_in or posedge nrst_in) begin
        if (nrst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(WIDTH+1){1'b0}};
            end
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
            ovf_pend_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= entry_s;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_pend_q <= ovf_pend_d;
            lost_q     <= lost_d;
        end
    end

    assign cap_data_out  = head_s[WIDTH-1:0];
    assign cap_ovf_out   = head_s[WIDTH];
    assign cap_valid_out = valid_s;
    assign cap_lost_out  = lost_q;
    assign level_out     = level_q;

endmodule

// File: tb/tb_event_capture.sv
// Directed self-checking bench for event_capture (WIDTH=8, DEPTH=4).
module tb_event_capture;
    logic       clk_in = 1'b0;
    logic       nrst_in = 1'b1;
    logic       en_ctl_in = 1'b0;
    logic [1:0] edge_sel_in = 2'b00;
    logic       evt_in = 1'b0;
    logic [7:0] count_in = 8'h00;
    logic       ovf_in = 1'b0;
    logic [7:0] cap_data_out;
    logic       cap_ovf_out;
    logic       cap_valid_out;
    logic       cap_ready_in = 1'b0;
    logic       cap_lost_out;
    logic       lost_clr_in = 1'b0;
    logic [2:0] level_out;

    int n_cmp = 0;
    int n_err = 0;

    event_capture #(.WIDTH(8), .DEPTH(4)) dut (
        .clk_in(clk_in), .nrst_in(nrst_in), .en_ctl_in(en_ctl_in), .edge_sel_in(edge_sel_in),
        .evt_in(evt_in), .count_in(count_in), .ovf_in(ovf_in), .cap_data_out(cap_data_out),
        .cap_ovf_out(cap_ovf_out), .cap_valid_out(cap_valid_out), .cap_ready_in(cap_ready_in),
        .cap_lost_out(cap_lost_out), .lost_clr_in(lost_clr_in), .level_out(level_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        nrst_in = 1'b1; en_ctl_in = 1'b0; edge_sel_in = 2'b00; evt_in = 1'b0;
        ovf_in = 1'b0; cap_ready_in = 1'b0; lost_clr_in = 1'b0; count_in = 8'h00;
        step(2);
        nrst_in = 1'b0;
        step(1);
    endtask

    // Starts at a negedge, ends at a negedge with the synchroniser settled low.
    task automatic rise_event(input logic [7:0] stamp, input logic pop_too);
        evt_in = 1'b1;
        step(2);
        count_in = stamp;
        cap_ready_in = pop_too;
        step(1);
        cap_ready_in = 1'b0;
        evt_in = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        nrst_in = 1'b1;
        step(2);
        n_cmp++; if (cap_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", cap_valid_out); end
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level_out); end
        n_cmp++; if (cap_lost_out !== 1'b0) begin n_err++; $display("FAIL reset_lost: got %0b want 0", cap_lost_out); end
        n_cmp++; if (cap_data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", cap_data_out); end
        nrst_in = 1'b0;
        step(1);
    endtask

    task automatic test_rise_capture();
        en_ctl_in = 1'b1; edge_sel_in = 2'b00;
        count_in = 8'h00; evt_in = 1'b1;
        step(1);
        n_cmp++; if (cap_valid_out !== 1'b0) begin n_err++; $display("FAIL rise_early1: got %0b want 0", cap_valid_out); end
        step(1);
        n_cmp++; if (cap_valid_out !== 1'b0) begin n_err++; $display("FAIL rise_early2: got %0b want 0", cap_valid_out); end
        count_in = 8'h10;
        step(1);
        n_cmp++; if (cap_valid_out !== 1'b1) begin n_err++; $display("FAIL rise_valid: got %0b want 1", cap_valid_out); end
        n_cmp++; if (cap_data_out !== 8'h10) begin n_err++; $display("FAIL rise_data: got %h want 10", cap_data_out); end
        n_cmp++; if (cap_ovf_out !== 1'b0) begin n_err++; $display("FAIL rise_ovf: got %0b want 0", cap_ovf_out); end
        n_cmp++; if (level_out !== 3'd1) begin n_err++; $display("FAIL rise_level: got %0d want 1", level_out); end
        evt_in = 1'b0; cap_ready_in = 1'b1;
        step(1);
        cap_ready_in = 1'b0;
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL rise_pop_level: got %0d want 0", level_out); end
        step(2);
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL rise_fall_ignored: got %0d want 0", level_out); end
    endtask

    task automatic test_both_edges();
        logic [7:0] stamps [4];
        int n = 0;
        edge_sel_in = 2'b10; cap_ready_in = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (cap_valid_out === 1'b1 && n < 4) begin stamps[n] = cap_data_out; n++; end
            count_in = 8'h30 + 8'(k);
            evt_in = (k < 5) ? 1'b1 : 1'b0;
            step(1);
        end
        cap_ready_in = 1'b0;
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL both_count: got %0d want 2", n); end
        if (n >= 2) begin
            n_cmp++; if (stamps[0] !== 8'h32) begin n_err++; $display("FAIL both_first: got %h want 32", stamps[0]); end
            n_cmp++; if (stamps[1] !== 8'h37) begin n_err++; $display("FAIL both_second: got %h want 37", stamps[1]); end
            n_cmp++; if (8'(stamps[1] - stamps[0]) !== 8'd5) begin n_err++; $display("FAIL both_delta: got %0d want 5", 8'(stamps[1] - stamps[0])); end
        end
        edge_sel_in = 2'b00;
    endtask

    task automatic test_overflow_tag();
        do_reset();
        en_ctl_in = 1'b1;
        rise_event(8'h20, 1'b0);
        ovf_in = 1'b1;
        step(1);
        ovf_in = 1'b0;
        step(1);
        rise_event(8'h28, 1'b0);
        n_cmp++; if (cap_data_out !== 8'h20 || cap_ovf_out !== 1'b0) begin n_err++; $display("FAIL ovf_first: got %h/%0b want 20/0", cap_data_out, cap_ovf_out); end
        cap_ready_in = 1'b1;
        step(1);
        cap_ready_in = 1'b0;
        n_cmp++; if (cap_data_out !== 8'h28 || cap_ovf_out !== 1'b1) begin n_err++; $display("FAIL ovf_second: got %h/%0b want 28/1", cap_data_out, cap_ovf_out); end
        cap_ready_in = 1'b1;
        step(1);
        cap_ready_in = 1'b0;
        n_cmp++; if (cap_valid_out !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %0b want 0", cap_valid_out); end
    endtask

    task automatic test_full_drop();
        logic [7:0] exp [4];
`ifdef CAP_OVERWRITE_EN
        exp = '{8'h42, 8'h43, 8'h44, 8'h45};
`else
        exp = '{8'h41, 8'h42, 8'h43, 8'h44};
`endif
        do_reset();
        en_ctl_in = 1'b1;
        for (int i = 0; i < 5; i++) rise_event(8'h41 + 8'(i), 1'b0);
        n_cmp++; if (level_out !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", level_out); end
        n_cmp++; if (cap_lost_out !== 1'b1) begin n_err++; $display("FAIL full_lost: got %0b want 1", cap_lost_out); end
        lost_clr_in = 1'b1;
        step(1);
        lost_clr_in = 1'b0;
        n_cmp++; if (cap_lost_out !== 1'b0) begin n_err++; $display("FAIL lost_clear: got %0b want 0", cap_lost_out); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cap_data_out !== exp[i]) begin n_err++; $display("FAIL full_pop%0d: got %h want %h", i, cap_data_out, exp[i]); end
            cap_ready_in = 1'b1;
            step(1);
            cap_ready_in = 1'b0;
        end
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL full_drained: got %0d want 0", level_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h52, 8'h53, 8'h54, 8'h55};
        do_reset();
        en_ctl_in = 1'b1;
        for (int i = 0; i < 4; i++) rise_event(8'h51 + 8'(i), 1'b0);
        rise_event(8'h55, 1'b1);
        n_cmp++; if (level_out !== 3'd4) begin n_err++; $display("FAIL pp_level: got %0d want 4", level_out); end
        n_cmp++; if (cap_lost_out !== 1'b0) begin n_err++; $display("FAIL pp_lost: got %0b want 0", cap_lost_out); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cap_data_out !== exp[i]) begin n_err++; $display("FAIL pp_pop%0d: got %h want %h", i, cap_data_out, exp[i]); end
            cap_ready_in = 1'b1;
            step(1);
            cap_ready_in = 1'b0;
        end
    endtask

    task automatic test_disable();
        do_reset();
        en_ctl_in = 1'b0; edge_sel_in = 2'b00;
        evt_in = 1'b1;
        step(5);
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL dis_nopush: got %0d want 0", level_out); end
        en_ctl_in = 1'b1;
        step(4);
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL dis_spurious: got %0d want 0", level_out); end
        evt_in = 1'b0;
        step(4);
        edge_sel_in = 2'b11;
        evt_in = 1'b1;
        step(4);
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL sel_none: got %0d want 0", level_out); end
        evt_in = 1'b0;
        step(4);
        edge_sel_in = 2'b00;
    endtask

    task automatic test_async_reset();
        do_reset();
        en_ctl_in = 1'b1;
        for (int i = 0; i < 3; i++) rise_event(8'h61 + 8'(i), 1'b0);
        n_cmp++; if (level_out !== 3'd3) begin n_err++; $display("FAIL ar_prefill: got %0d want 3", level_out); end
        #2 nrst_in = 1'b1;
        #1;
        n_cmp++; if (cap_valid_out !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %0b want 0", cap_valid_out); end
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL ar_level: got %0d want 0", level_out); end
        n_cmp++; if (cap_lost_out !== 1'b0) begin n_err++; $display("FAIL ar_lost: got %0b want 0", cap_lost_out); end
        step(2);
        nrst_in = 1'b0;
        step(4);
        n_cmp++; if (level_out !== 3'd0) begin n_err++; $display("FAIL ar_no_capture: got %0d want 0", level_out); end
    endtask

    initial begin
        test_reset();
        test_rise_capture();
        test_both_edges();
        test_overflow_tag();
        test_full_drop();
        test_back_to_back();
        test_disable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
